hint_conflict_checker: RTL and testbench
========================================

// Module: hint_conflict_checker
// PURPOSE
//  Conflict-check stage directly downstream of the per-task-type dequeue FIFO.
//  - Takes the FIFO head (task + CQ slot) and compares its hint against a table of in-flight tasks.
//  - Accepts (dispatches to core, allocates an entry) or rejects (FIFO re-enqueues the head).
//  - Frees entries when the core reports task completion by CQ slot.
// PARAMETERS
//  ID           0   instance id, debug only
//  NUM_ENTRIES  8   in-flight table depth, power of 2, 2..32
// PORTS
//  clk           in   1                       single clock
//  rst           in   1                       synchronous reset, active-high
//  in_valid      in   1                       FIFO head valid
//  in_task       in   $bits(task_t)           FIFO head task (.hint, .ts)
//  in_slot       in   $bits(cq_slice_slot_t)  FIFO head CQ slot
//  resp          out  1                       0 = accept, 1 = reject
//  resp_valid    out  1                       resp strobe; the FIFO pops on it
//  out_valid     out  1                       task offered to core
//  out_ready     in   1                       core accepts
//  out_task      out  $bits(task_t)           dispatched task
//  out_slot      out  $bits(cq_slice_slot_t)  dispatched slot
//  fin_valid     in   1                       task finished
//  fin_slot      in   $bits(cq_slice_slot_t)  slot of finished task
//  table_empty   out  1                       no valid entries, for termination
//  reg_bus       reg_bus_t.master             CSR access
// BEHAVIOUR
//  Reset: state=IDLE, all entry valids 0; resp_valid=0, resp=0, out_valid=0,
//   table_empty=1, reg_bus.rvalid=0, counters 0.
//  FSM:
//   IDLE:     if in_valid, latch {in_task, in_slot} into hold regs -> CHECK.
//   CHECK:    hit = any valid entry with hint == held hint; full = all entries valid.
//             hit|full -> REJECT, else -> DISPATCH.
//   REJECT:   resp_valid=1, resp=1 for exactly one cycle -> IDLE.
//   DISPATCH: out_valid=1 with held task/slot, stable until out_ready.
//             On out_valid&out_ready, in the same cycle:
//               - resp_valid=1, resp=0;
//               - write the lowest-index free entry {valid, hint, slot};
//               - -> IDLE.
//  Latency: head seen in IDLE (cycle 0) -> resp at cycle 2 for reject, or at
//   cycle >=2 for accept (equal to 2 when out_ready is already high).
//  Timing rules:
//   - resp_valid is never asserted in IDLE, so a fresh FIFO head is not sampled
//     in the same cycle as a pop.
//   - in_* is ignored outside IDLE.
//  Free: fin_valid clears every valid entry whose slot == fin_slot. Unknown slot: no-op.
//  Simultaneous events:
//   - A free in the same cycle as CHECK is not visible to that compare; the
//     check is conservative.
//   - Alloc and free in the same cycle both take effect.
//   - fin_slot equal to the slot being allocated that same cycle: the allocation wins.
//  Occupancy counter: +1 on alloc, -1 per cleared entry, width $clog2(NUM_ENTRIES)+1.
//   table_empty = (occupancy == 0).
//  Reset mid-operation: drops held task without a resp. The upstream FIFO is
//   reset by the same reset.
//  reg_bus:
//   - reads: rvalid one cycle after arvalid; rdata by araddr:
//       CC_OCCUPANCY, CC_ACCEPT_COUNT, CC_REJECT_COUNT. Other addresses: rdata=0.
//   - writes: CC_CLEAR_STATS (any data) zeroes both counters.
// CONFIGURATION
//  CC_STATS_EN:
//   - defined: 32-bit saturating accept/reject counters, incremented on each resp_valid.
//   - undefined: counters are absent, reads of CC_ACCEPT_COUNT/CC_REJECT_COUNT
//     return 0, and CC_CLEAR_STATS writes are ignored.
//   - Behaviour of all other ports is identical either way.
// TESTING
//  1 Empty table, head hint=0x12, out_ready=1 -> out_valid at cycle 2, resp_valid=1
//    resp=0 same cycle, table_empty=0, occupancy=1.
//  2 Entry hint=0x12 in flight, head hint=0x12 -> resp_valid=1 resp=1 at cycle 2,
//    no out_valid, occupancy unchanged.
//  3 Fill 8 distinct hints, then head hint=0x99 -> reject on full; fin_valid slot of
//    entry 3, retry -> accepted into entry 3.
//  4 out_ready=0 for 5 cycles in DISPATCH -> out_task/out_slot stable, no resp until
//    the ready cycle.
//  5 fin_valid for the conflicting slot in the CHECK cycle -> still reject; next retry accepts.
//  6 CC_STATS_EN: 3 accepts + 2 rejects -> CC_ACCEPT_COUNT=3, CC_REJECT_COUNT=2;
//    CC_CLEAR_STATS -> both 0. Without the macro, both read 0.

Source files
------------

// File: rtl/hint_conflict_checker.sv
// hint_conflict_checker: gates dequeue-FIFO heads against a table of in-flight hints.
// Define CC_STATS_EN to add saturating accept/reject counters readable over the CSR bus.
module hint_conflict_checker #(
    parameter int ID          = 0,
    parameter int NUM_ENTRIES = 8,
    parameter int HINT_W      = 16,
    parameter int TS_W        = 16,
    parameter int SLOT_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int TASK_W      = HINT_W + TS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [TASK_W-1:0] in_task,
    input  logic [SLOT_W-1:0] in_slot,
    output logic              resp,
    output logic              resp_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TASK_W-1:0] out_task,
    output logic [SLOT_W-1:0] out_slot,
    input  logic              fin_valid,
    input  logic [SLOT_W-1:0] fin_slot,
    output logic              table_empty,
    input  logic              reg_arvalid,
    input  logic [ADDR_W-1:0] reg_araddr,
    output logic              reg_rvalid,
    output logic [31:0]       reg_rdata,
    input  logic              reg_wvalid,
    input  logic [ADDR_W-1:0] reg_waddr,
    input  logic [31:0]       reg_wdata
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] CC_OCCUPANCY    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] CC_ACCEPT_COUNT = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] CC_REJECT_COUNT = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] CC_CLEAR_STATS  = ADDR_W'(8'h0C);
    localparam int unused_id = ID;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REJECT, S_DISPATCH} state_t;

    state_t state_q, state_d;
    logic [TASK_W-1:0] hold_task_q, hold_task_d;
    logic [SLOT_W-1:0] hold_slot_q, hold_slot_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0][HINT_W-1:0] hint_q, hint_d;
    logic [NUM_ENTRIES-1:0][SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0] occ_q, occ_d, clr_cnt;
    logic rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] acc_val, rej_val;
    logic [HINT_W-1:0] held_hint;
    logic [IDX_W-1:0] free_idx;
    logic free_found, hit, full, alloc;
    logic unused_bits;

    assign held_hint   = hold_task_q[TASK_W-1 -: HINT_W];
    assign out_task    = hold_task_q;
    assign out_slot    = hold_slot_q;
    assign table_empty = (occ_q == '0);
    assign reg_rvalid  = rvalid_q;
    assign reg_rdata   = rdata_q;
    assign unused_bits = ^{reg_wdata, reg_wvalid, reg_waddr};

    // Compare uses registered table only, so a same-cycle free is not seen (conservative).
    always_comb begin
        hit        = 1'b0;
        full       = &valid_q;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && hint_q[i] == held_hint) hit = 1'b1;
            if (!free_found && !valid_q[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_task_d = hold_task_q;
        hold_slot_d = hold_slot_q;
        resp_valid  = 1'b0;
        resp        = 1'b0;
        out_valid   = 1'b0;
        alloc       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    hold_task_d = in_task;
                    hold_slot_d = in_slot;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: state_d = (hit || full) ? S_REJECT : S_DISPATCH;
            S_REJECT: begin
                resp_valid = 1'b1;
                resp       = 1'b1;
                state_d    = S_IDLE;
            end
            S_DISPATCH: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    resp_valid = 1'b1;
                    alloc      = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Free first, then allocate, so an alloc whose slot matches fin_slot survives.
    always_comb begin
        valid_d = valid_q;
        hint_d  = hint_q;
        slot_d  = slot_q;
        clr_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (fin_valid && valid_q[i] && slot_q[i] == fin_slot) begin
                valid_d[i] = 1'b0;
                clr_cnt    = clr_cnt + CNT_W'(1);
            end
        end
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            hint_d[free_idx]  = held_hint;
            slot_d[free_idx]  = hold_slot_q;
        end
        occ_d = occ_q - clr_cnt + (alloc ? CNT_W'(1) : CNT_W'(0));
    end

    always_comb begin
        rvalid_d = reg_arvalid;
        rdata_d  = '0;
        if (reg_arvalid) begin
            case (reg_araddr)
                CC_OCCUPANCY:    rdata_d = 32'(occ_q);
                CC_ACCEPT_COUNT: rdata_d = acc_val;
                CC_REJECT_COUNT: rdata_d = rej_val;
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_task_q <= '0;
            hold_slot_q <= '0;
            valid_q     <= '0;
            hint_q      <= '0;
            slot_q      <= '0;
            occ_q       <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_task_q <= hold_task_d;
            hold_slot_q <= hold_slot_d;
            valid_q     <= valid_d;
            hint_q      <= hint_d;
            slot_q      <= slot_d;
            occ_q       <= occ_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef CC_STATS_EN
    logic [31:0] acc_q, acc_d, rej_q, rej_d;
    logic clr_stats;

    always_comb begin
        clr_stats = reg_wvalid && (reg_waddr == CC_CLEAR_STATS);
        acc_d     = acc_q;
        rej_d     = rej_q;
        if (clr_stats) begin
            acc_d = '0;
            rej_d = '0;
        end else if (resp_valid) begin
            if (resp) begin
                if (rej_q != '1) rej_d = rej_q + 32'd1;
            end else if (acc_q != '1) begin
                acc_d = acc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            acc_q <= acc_d;
            rej_q <= rej_d;
        end
    end

    assign acc_val = acc_q;
    assign rej_val = rej_q;
`else
    assign acc_val = '0;
    assign rej_val = '0;
`endif

endmodule

// File: tb/tb_hint_conflict_checker.sv
// Self-checking bench for hint_conflict_checker: scoreboard of expected responses
// popped by a negedge monitor, plus per-scenario inline checks of occupancy and CSRs.
module tb_hint_conflict_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_task;
    logic [7:0]  in_slot;
    logic        resp, resp_valid, out_valid, out_ready;
    logic [31:0] out_task;
    logic [7:0]  out_slot;
    logic        fin_valid;
    logic [7:0]  fin_slot;
    logic        table_empty;
    logic        reg_arvalid, reg_rvalid, reg_wvalid;
    logic [7:0]  reg_araddr, reg_waddr;
    logic [31:0] reg_rdata, reg_wdata;

    typedef struct {
        bit          rej;
        logic [31:0] tsk;
        logic [7:0]  slot;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int ts_ctr = 0;

    always #5 clk = ~clk;

    hint_conflict_checker #(.ID(0), .NUM_ENTRIES(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_task(in_task), .in_slot(in_slot),
        .resp(resp), .resp_valid(resp_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_task(out_task), .out_slot(out_slot),
        .fin_valid(fin_valid), .fin_slot(fin_slot),
        .table_empty(table_empty),
        .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
        .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
    );

    // Scoreboard: every resp strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got resp=%0d, none expected", resp);
            end else begin
                mon_e = sb_q.pop_front();
                if (resp !== mon_e.rej) begin
                    errors++;
                    $display("FAIL resp_value got %0d want %0d (slot %0d)", resp, mon_e.rej, mon_e.slot);
                end
                checks++;
                if (mon_e.rej) begin
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL reject_out_valid got %0d want 0", out_valid);
                    end
                end else if (out_valid !== 1'b1 || out_task !== mon_e.tsk || out_slot !== mon_e.slot) begin
                    errors++;
                    $display("FAIL dispatch got v=%0d task=%h slot=%0d want v=1 task=%h slot=%0d",
                             out_valid, out_task, out_slot, mon_e.tsk, mon_e.slot);
                end
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send(input logic [15:0] hint, input logic [7:0] slot, input bit exp_rej,
                        input int fin_cyc, input logic [7:0] fin_s);
        exp_t e;
        int lat;
        bit got;
        ts_ctr++;
        e.rej  = exp_rej;
        e.tsk  = {hint, ts_ctr[15:0]};
        e.slot = slot;
        sb_q.push_back(e);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_task   = e.tsk;
        in_slot   = slot;
        @(posedge clk); #1;
        in_task   = 32'hDEAD_BEEF;
        in_slot   = 8'hEE;
        fin_valid = (fin_cyc == 1);
        fin_slot  = fin_s;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
                in_valid  = 1'b0;
                fin_valid = (fin_cyc == lat);
            end
        end
        checks++;
        if (!got || lat != 2) begin
            errors++;
            $display("FAIL resp_latency got %0d (seen=%0d) want 2 for slot %0d", lat, got, slot);
        end
        @(posedge clk); #1;
        fin_valid = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic free_slot(input logic [7:0] s);
        fin_valid = 1'b1;
        fin_slot  = s;
        @(posedge clk); #1;
        fin_valid = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        reg_arvalid = 1'b1;
        reg_araddr  = a;
        @(posedge clk); #1;
        reg_arvalid = 1'b0;
        checks++;
        if (reg_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rvalid addr=%h got %0d want 1", a, reg_rvalid);
        end
        d = reg_rdata;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        reg_wvalid = 1'b1;
        reg_waddr  = a;
        reg_wdata  = d;
        @(posedge clk); #1;
        reg_wvalid = 1'b0;
    endtask

    task automatic check_occ(input int exp, input string name);
        logic [31:0] d;
        reg_read(8'h00, d);
        checks++;
        if (d !== 32'(exp)) begin
            errors++;
            $display("FAIL occ_%s got %0d want %0d", name, d, exp);
        end
        checks++;
        if (table_empty !== (exp == 0)) begin
            errors++;
            $display("FAIL empty_%s got %0d want %0d", name, table_empty, (exp == 0));
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        in_valid = 1'b0; in_task = '0; in_slot = '0; out_ready = 1'b0;
        fin_valid = 1'b0; fin_slot = '0;
        reg_arvalid = 1'b0; reg_araddr = '0; reg_wvalid = 1'b0; reg_waddr = '0; reg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp !== 1'b0 || out_valid !== 1'b0 || table_empty !== 1'b1 || reg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%0d r=%0d ov=%0d te=%0d rdv=%0d want 0 0 0 1 0",
                     resp_valid, resp, out_valid, table_empty, reg_rvalid);
        end
        check_occ(0, "reset");
        reg_read(8'h04, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", d); end
    endtask

    task automatic test_accept_conflict();
        send(16'h0012, 8'd1, 1'b0, 0, 8'd0);
        check_occ(1, "accept");
        send(16'h0012, 8'd2, 1'b1, 0, 8'd0);
        check_occ(1, "conflict");
    endtask

    task automatic test_full();
        for (int i = 0; i < 7; i++) send(16'h0021 + 16'(i), 8'd10 + 8'(i), 1'b0, 0, 8'd0);
        check_occ(8, "filled");
        send(16'h0099, 8'd20, 1'b1, 0, 8'd0);
        check_occ(8, "full_reject");
        free_slot(8'd12);
        check_occ(7, "freed_e3");
        send(16'h0099, 8'd20, 1'b0, 0, 8'd0);
        send(16'h0098, 8'd21, 1'b1, 0, 8'd0);
        free_slot(8'd99);
        check_occ(8, "unknown_free");
        free_slot(8'd1);
        for (int i = 0; i < 7; i++) if (i != 2) free_slot(8'd10 + 8'(i));
        free_slot(8'd20);
        check_occ(0, "drained");
    endtask

    task automatic test_stall();
        exp_t e;
        ts_ctr++;
        e.rej = 1'b0; e.tsk = {16'h0030, ts_ctr[15:0]}; e.slot = 8'd30;
        sb_q.push_back(e);
        out_ready = 1'b0;
        in_valid = 1'b1; in_task = e.tsk; in_slot = e.slot;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || resp_valid !== 1'b0 || out_task !== e.tsk || out_slot !== e.slot) begin
                errors++;
                $display("FAIL stall_c%0d got ov=%0d rv=%0d task=%h slot=%0d want 1 0 %h %0d",
                         i, out_valid, resp_valid, out_task, out_slot, e.tsk, e.slot);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got rv=%0d want 1", resp_valid);
        end
        @(posedge clk); #1;
        check_occ(1, "stall");
    endtask

    task automatic test_simultaneous();
        send(16'h0040, 8'd40, 1'b0, 0, 8'd0);
        send(16'h0040, 8'd41, 1'b1, 1, 8'd40);
        check_occ(1, "free_in_check");
        send(16'h0040, 8'd41, 1'b0, 0, 8'd0);
        check_occ(2, "retry");
        send(16'h0050, 8'd50, 1'b0, 2, 8'd50);
        check_occ(3, "alloc_wins");
        send(16'h0060, 8'd60, 1'b0, 2, 8'd41);
        check_occ(3, "alloc_and_free");
        free_slot(8'd50);
        check_occ(2, "free_new");
        send(16'h0070, 8'd70, 1'b0, 0, 8'd0);
        send(16'h0071, 8'd70, 1'b0, 0, 8'd0);
        free_slot(8'd70);
        check_occ(2, "dup_slot_free");
    endtask

    task automatic test_stats();
        logic [31:0] d;
        int exp_acc, exp_rej;
`ifdef CC_STATS_EN
        exp_acc = 3; exp_rej = 2;
`else
        exp_acc = 0; exp_rej = 0;
`endif
        reg_write(8'h0C, 32'h1);
        for (int i = 0; i < 3; i++) send(16'h0080 + 16'(i), 8'd80 + 8'(i), 1'b0, 0, 8'd0);
        send(16'h0080, 8'd83, 1'b1, 0, 8'd0);
        send(16'h0081, 8'd84, 1'b1, 0, 8'd0);
        reg_read(8'h04, d);
        checks++;
        if (d !== 32'(exp_acc)) begin errors++; $display("FAIL stats_acc got %0d want %0d", d, exp_acc); end
        reg_read(8'h08, d);
        checks++;
        if (d !== 32'(exp_rej)) begin errors++; $display("FAIL stats_rej got %0d want %0d", d, exp_rej); end
        reg_write(8'h0C, 32'h0);
        reg_read(8'h04, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL clear_acc got %0d want 0", d); end
        reg_read(8'h08, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL clear_rej got %0d want 0", d); end
        reg_read(8'h10, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
        check_occ(5, "stats");
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b1;
        in_valid = 1'b1; in_task = 32'h00AA_0001; in_slot = 8'd90;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_c%0d got rv=%0d ov=%0d want 0 0", i, resp_valid, out_valid);
            end
            @(posedge clk); #1;
        end
        check_occ(0, "midreset");
        send(16'h0030, 8'd30, 1'b0, 0, 8'd0);
        check_occ(1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_accept_conflict();
        test_full();
        test_stall();
        test_simultaneous();
        test_stats();
        test_reset_midop();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
